lsu_mem_ctrl: RTL and testbench

//  CPU-side load/store initiator for the word-wide data RAM (1-cycle synchronous read, rising-edge clocked).

---
 rtl/lsu_mem_ctrl_pkg.sv | 17 +
 rtl/lsu_mem_ctrl_if.sv | 26 ++
 rtl/lsu_mem_ctrl_byte_lane.sv | 42 ++++
 rtl/lsu_mem_ctrl.sv | 126 ++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared encodings for the load/store unit: access sizes and controller states.
package lsu_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_BAD  = 2'b11
  } size_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOAD  = 2'b01,
    MERGE = 2'b10
  } state_t;

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Request/response handshake between the execute stage (master) and the LSU (slave).
interface lsu_mem_ctrl_if;

  logic        req_valid;
  logic        req_ready;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  size;
  logic        is_unsigned;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] rdata;

  modport master (
    output req_valid, mem_read, mem_write, size, is_unsigned, addr, wdata,
    input  req_ready, resp_valid, resp_err, rdata
  );

  modport slave (
    input  req_valid, mem_read, mem_write, size, is_unsigned, addr, wdata,
    output req_ready, resp_valid, resp_err, rdata
  );

endinterface

// File: rtl/lsu_mem_ctrl_byte_lane.sv
// Little-endian lane extraction (with sign/zero extension) and lane merge for
// sub-word accesses; shared by the load and read-modify-write paths.
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  size_t       size,
  input  logic        uns,
  input  logic [31:0] new_data,
  output logic [31:0] extracted,
  output logic [31:0] merged
);

  logic [4:0]  lane_sh;
  logic [31:0] shifted;
  logic [31:0] lane_mask;

  assign lane_sh = {off, 3'b000};
  assign shifted = word >> lane_sh;

  always_comb begin
    extracted = shifted;
    case (size)
      SIZE_BYTE: extracted = {{24{shifted[7] & ~uns}}, shifted[7:0]};
      SIZE_HALF: extracted = {{16{shifted[15] & ~uns}}, shifted[15:0]};
      default:   extracted = shifted;
    endcase
  end

  // Word accesses are always aligned, so the shift is zero and the full mask replaces everything.
  always_comb begin
    lane_mask = 32'hFFFF_FFFF;
    case (size)
      SIZE_BYTE: lane_mask = 32'h0000_00FF << lane_sh;
      SIZE_HALF: lane_mask = 32'h0000_FFFF << lane_sh;
      default:   lane_mask = 32'hFFFF_FFFF;
    endcase
    merged = (word & ~lane_mask) | ((new_data << lane_sh) & lane_mask);
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator for a 1-cycle synchronous data RAM: direct word stores,
// read-modify-write sub-word stores, extended loads, and error screening.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W      = 14,
  parameter bit CHECK_RANGE = 1'b1
)(
  input  logic              clock,
  input  logic              rst_n,
  lsu_mem_ctrl_if.slave     bus,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_din,
  input  logic [31:0]       ram_dout
);

  state_t              state;
  state_t              state_next;
  size_t               req_size;
  logic                accept;
  logic                range_err;
  logic                align_err;
  logic                req_err;
  logic                word_store;
  logic [ADDR_W-1:0]   lat_word;
  logic [1:0]          lat_off;
  size_t               lat_size;
  logic                lat_uns;
  logic [31:0]         lat_wdata;
  logic [31:0]         extracted;
  logic [31:0]         merged;

  assign req_size   = size_t'(bus.size);
  assign accept     = (state == IDLE) & bus.req_valid & (bus.mem_read | bus.mem_write);
  assign range_err  = CHECK_RANGE && ((bus.addr >> (ADDR_W + 2)) != 32'd0);
  assign align_err  = ((req_size == SIZE_HALF) && bus.addr[0]) ||
                      ((req_size == SIZE_WORD) && (bus.addr[1:0] != 2'b00));
  // Asking for a read and a write at once is accepted but answered with an error.
  assign req_err    = (bus.mem_read & bus.mem_write) | (req_size == SIZE_BAD) | align_err | range_err;
  assign word_store = bus.mem_write & (req_size == SIZE_WORD);

  lsu_byte_lane u_lane (
    .word      (ram_dout),
    .off       (lat_off),
    .size      (lat_size),
    .uns       (lat_uns),
    .new_data  (lat_wdata),
    .extracted (extracted),
    .merged    (merged)
  );

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = IDLE;
    if (accept && !req_err) begin
      if (bus.mem_read)     state_next = LOAD;
      else if (!word_store) state_next = MERGE;
    end
  end

  // The whole RAM-facing side is forced to zero while reset is held, which kills a write mid-MERGE.
  always_comb begin
    bus.req_ready = rst_n & (state == IDLE);
    ram_we        = 1'b0;
    ram_addr      = lat_word;
    ram_din       = merged;
    case (state)
      IDLE: begin
        ram_addr = bus.addr[ADDR_W+1:2];
        ram_din  = bus.wdata;
        ram_we   = accept & ~req_err & word_store;
      end
      MERGE:   ram_we = 1'b1;
      default: ram_we = 1'b0;
    endcase
    if (!rst_n) begin
      ram_we   = 1'b0;
      ram_addr = '0;
      ram_din  = '0;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      bus.resp_valid <= 1'b0;
      bus.resp_err   <= 1'b0;
      bus.rdata      <= '0;
      lat_word       <= '0;
      lat_off        <= '0;
      lat_size       <= SIZE_BYTE;
      lat_uns        <= 1'b0;
      lat_wdata      <= '0;
    end else begin
      bus.resp_valid <= 1'b0;
      bus.resp_err   <= 1'b0;
      bus.rdata      <= '0;
      if (accept) begin
        lat_word  <= bus.addr[ADDR_W+1:2];
        lat_off   <= bus.addr[1:0];
        lat_size  <= req_size;
        lat_uns   <= bus.is_unsigned;
        lat_wdata <= bus.wdata;
      end
      case (state)
        IDLE: begin
          if (accept && (req_err || word_store)) begin
            bus.resp_valid <= 1'b1;
            bus.resp_err   <= req_err;
          end
        end
        LOAD: begin
          bus.resp_valid <= 1'b1;
          bus.rdata      <= extracted;
        end
        MERGE:   bus.resp_valid <= 1'b1;
        default: bus.resp_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed self-checking bench for lsu_mem_ctrl with a behavioural 1-cycle synchronous RAM.
module tb_lsu_mem_ctrl;

  localparam int ADDR_W = 14;

  logic              clock = 1'b0;
  logic              rst_n = 1'b0;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_din;
  logic [31:0]       ram_dout = '0;
  logic [31:0]       mem [0:(1<<ADDR_W)-1];
  int                vectors = 0;
  int                miscompares = 0;
  int                we_count = 0;

  lsu_mem_ctrl_if bus();

  lsu_mem_ctrl #(.ADDR_W(ADDR_W), .CHECK_RANGE(1'b1)) dut (
    .clock    (clock),
    .rst_n    (rst_n),
    .bus      (bus),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_dout (ram_dout)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  always @(posedge clock) if (ram_we) we_count <= we_count + 1;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] d);
    bus.req_valid   = 1'b1;
    bus.mem_read    = rd;
    bus.mem_write   = wr;
    bus.size        = sz;
    bus.is_unsigned = uns;
    bus.addr        = a;
    bus.wdata       = d;
  endtask

  task automatic release_bus();
    bus.req_valid = 1'b0;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
  endtask

  task automatic word_store(input logic [31:0] a, input logic [31:0] d);
    drive(1'b0, 1'b1, 2'b10, 1'b0, a, d);
    tick();
    release_bus();
    tick();
  endtask

  task automatic test_reset();
    release_bus();
    bus.size = 2'b10; bus.is_unsigned = 1'b0; bus.addr = 32'h10; bus.wdata = 32'h0;
    rst_n = 1'b0;
    #3;
    vectors++; if (bus.req_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ready: got %b expected 0", bus.req_ready); end
    vectors++; if (bus.resp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_resp_valid: got %b expected 0", bus.resp_valid); end
    vectors++; if (bus.resp_err !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_resp_err: got %b expected 0", bus.resp_err); end
    vectors++; if (bus.rdata !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_rdata: got %h expected 0", bus.rdata); end
    vectors++; if (ram_we !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ram_we: got %b expected 0", ram_we); end
    tick(); tick();
    rst_n = 1'b1;
    #1;
    vectors++; if (bus.req_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_release_ready: got %b expected 1", bus.req_ready); end
    tick();
  endtask

  task automatic test_word_store();
    drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF);
    #1;
    vectors++; if (ram_we !== 1'b1) begin miscompares++; $display("[TB] FAIL wst_we: got %b expected 1", ram_we); end
    vectors++; if (ram_addr !== 14'd4) begin miscompares++; $display("[TB] FAIL wst_addr: got %h expected 4", ram_addr); end
    vectors++; if (ram_din !== 32'hDEAD_BEEF) begin miscompares++; $display("[TB] FAIL wst_din: got %h expected deadbeef", ram_din); end
    tick();
    release_bus();
    vectors++; if (bus.resp_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL wst_resp_valid: got %b expected 1", bus.resp_valid); end
    vectors++; if (bus.resp_err !== 1'b0) begin miscompares++; $display("[TB] FAIL wst_resp_err: got %b expected 0", bus.resp_err); end
    vectors++; if (bus.rdata !== 32'h0) begin miscompares++; $display("[TB] FAIL wst_rdata: got %h expected 0", bus.rdata); end
    vectors++; if (mem[4] !== 32'hDEAD_BEEF) begin miscompares++; $display("[TB] FAIL wst_mem: got %h expected deadbeef", mem[4]); end
    tick();
    vectors++; if (bus.resp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL wst_resp_drop: got %b expected 0", bus.resp_valid); end
  endtask

  task automatic test_loads();
    logic [31:0] la [7] = '{32'h13, 32'h13, 32'h10, 32'h12, 32'h10, 32'h10, 32'h11};
    logic [1:0]  ls [7] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b00};
    logic        lu [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] le [7] = '{32'hFFFF_FFDE, 32'h0000_00DE, 32'hFFFF_FFEF, 32'hFFFF_DEAD,
                            32'h0000_BEEF, 32'hDEAD_BEEF, 32'h0000_00BE};
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 1'b0, ls[i], lu[i], la[i], 32'hFFFF_FFFF);
      #1;
      vectors++; if (ram_we !== 1'b0) begin miscompares++; $display("[TB] FAIL load%0d_we: got %b expected 0", i, ram_we); end
      tick();
      release_bus();
      vectors++; if (bus.req_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL load%0d_ready_c1: got %b expected 0", i, bus.req_ready); end
      tick();
      vectors++; if (bus.resp_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL load%0d_resp_valid: got %b expected 1", i, bus.resp_valid); end
      vectors++; if (bus.resp_err !== 1'b0) begin miscompares++; $display("[TB] FAIL load%0d_resp_err: got %b expected 0", i, bus.resp_err); end
      vectors++; if (bus.rdata !== le[i]) begin miscompares++; $display("[TB] FAIL load%0d_rdata: got %h expected %h", i, bus.rdata, le[i]); end
    end
    tick();
    vectors++; if (bus.resp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL load_resp_drop: got %b expected 0", bus.resp_valid); end
  endtask

  task automatic test_rmw();
    word_store(32'h10, 32'hDEAD_BEEF);
    drive(1'b0, 1'b1, 2'b01, 1'b0, 32'h12, 32'hAAAA_1234);
    #1;
    vectors++; if (ram_we !== 1'b0) begin miscompares++; $display("[TB] FAIL rmw_accept_we: got %b expected 0", ram_we); end
    tick();
    release_bus();
    vectors++; if (ram_we !== 1'b1) begin miscompares++; $display("[TB] FAIL rmw_merge_we: got %b expected 1", ram_we); end
    vectors++; if (ram_addr !== 14'd4) begin miscompares++; $display("[TB] FAIL rmw_merge_addr: got %h expected 4", ram_addr); end
    vectors++; if (ram_din !== 32'h1234_BEEF) begin miscompares++; $display("[TB] FAIL rmw_merge_din: got %h expected 1234beef", ram_din); end
    vectors++; if (bus.req_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL rmw_merge_ready: got %b expected 0", bus.req_ready); end
    tick();
    vectors++; if (bus.resp_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL rmw_resp_valid: got %b expected 1", bus.resp_valid); end
    vectors++; if (mem[4] !== 32'h1234_BEEF) begin miscompares++; $display("[TB] FAIL rmw_mem: got %h expected 1234beef", mem[4]); end
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    tick();
    release_bus();
    tick();
    vectors++; if (bus.rdata !== 32'h1234_BEEF) begin miscompares++; $display("[TB] FAIL rmw_readback: got %h expected 1234beef", bus.rdata); end
    drive(1'b0, 1'b1, 2'b00, 1'b0, 32'h11, 32'h0000_0155);
    tick();
    release_bus();
    tick();
    vectors++; if (mem[4] !== 32'h1234_55EF) begin miscompares++; $display("[TB] FAIL rmw_byte_mem: got %h expected 123455ef", mem[4]); end
    tick();
  endtask

  task automatic test_errors();
    logic        er [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic        ew [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [1:0]  es [8] = '{2'b10, 2'b10, 2'b01, 2'b11, 2'b10, 2'b10, 2'b00, 2'b01};
    logic [31:0] ea [8] = '{32'h11, 32'h0001_0000, 32'h13, 32'h10, 32'h10, 32'h12, 32'h8000_0010, 32'h15};
    int we_before;
    we_before = we_count;
    for (int i = 0; i < 8; i++) begin
      drive(er[i], ew[i], es[i], 1'b0, ea[i], 32'h5A5A_5A5A);
      #1;
      vectors++; if (ram_we !== 1'b0) begin miscompares++; $display("[TB] FAIL err%0d_we: got %b expected 0", i, ram_we); end
      tick();
      release_bus();
      vectors++; if (bus.resp_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL err%0d_resp_valid: got %b expected 1", i, bus.resp_valid); end
      vectors++; if (bus.resp_err !== 1'b1) begin miscompares++; $display("[TB] FAIL err%0d_resp_err: got %b expected 1", i, bus.resp_err); end
      vectors++; if (bus.rdata !== 32'h0) begin miscompares++; $display("[TB] FAIL err%0d_rdata: got %h expected 0", i, bus.rdata); end
      vectors++; if (bus.req_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL err%0d_ready: got %b expected 1", i, bus.req_ready); end
    end
    tick();
    vectors++; if (we_count !== we_before) begin miscompares++; $display("[TB] FAIL err_no_writes: got %0d writes expected %0d", we_count, we_before); end
    drive(1'b0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    tick();
    release_bus();
    vectors++; if (bus.resp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL noop_resp_valid: got %b expected 0", bus.resp_valid); end
    vectors++; if (mem[4] !== 32'h1234_55EF) begin miscompares++; $display("[TB] FAIL err_mem_intact: got %h expected 123455ef", mem[4]); end
    tick();
  endtask

  task automatic test_reset_mid_merge();
    word_store(32'h10, 32'hDEAD_BEEF);
    drive(1'b0, 1'b1, 2'b00, 1'b0, 32'h10, 32'h0000_0077);
    tick();
    release_bus();
    vectors++; if (ram_we !== 1'b1) begin miscompares++; $display("[TB] FAIL midrst_pre_we: got %b expected 1", ram_we); end
    rst_n = 1'b0;
    #1;
    vectors++; if (ram_we !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_we: got %b expected 0", ram_we); end
    vectors++; if (bus.req_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_ready: got %b expected 0", bus.req_ready); end
    vectors++; if (ram_din !== 32'h0) begin miscompares++; $display("[TB] FAIL midrst_din: got %h expected 0", ram_din); end
    vectors++; if (ram_addr !== 14'd0) begin miscompares++; $display("[TB] FAIL midrst_addr: got %h expected 0", ram_addr); end
    vectors++; if (bus.resp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_resp_valid: got %b expected 0", bus.resp_valid); end
    tick();
    vectors++; if (mem[4] !== 32'hDEAD_BEEF) begin miscompares++; $display("[TB] FAIL midrst_mem: got %h expected deadbeef", mem[4]); end
    vectors++; if (bus.rdata !== 32'h0) begin miscompares++; $display("[TB] FAIL midrst_rdata: got %h expected 0", bus.rdata); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFE_F00D);
    tick();
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    vectors++; if (bus.resp_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_store_resp: got %b expected 1", bus.resp_valid); end
    vectors++; if (bus.req_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_ready_resp: got %b expected 1", bus.req_ready); end
    tick();
    release_bus();
    vectors++; if (bus.req_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_ready_load: got %b expected 0", bus.req_ready); end
    tick();
    vectors++; if (bus.rdata !== 32'hCAFE_F00D) begin miscompares++; $display("[TB] FAIL b2b_load_rdata: got %h expected cafef00d", bus.rdata); end
    drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h30, 32'h1111_1111);
    tick();
    drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h34, 32'h2222_2222);
    #1;
    vectors++; if (ram_we !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_second_we: got %b expected 1", ram_we); end
    tick();
    release_bus();
    tick();
    vectors++; if (mem[12] !== 32'h1111_1111) begin miscompares++; $display("[TB] FAIL b2b_mem12: got %h expected 11111111", mem[12]); end
    vectors++; if (mem[13] !== 32'h2222_2222) begin miscompares++; $display("[TB] FAIL b2b_mem13: got %h expected 22222222", mem[13]); end
  endtask

  initial begin
    test_reset();
    test_word_store();
    test_loads();
    test_rmw();
    test_errors();
    test_reset_mid_merge();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
